// File: rtl/key_pkg.sv
// Shared constants, error codes and FSM state type for the c499 key loader.
package key_pkg;

  localparam int unsigned KEY_W  = 45;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NB     = (KEY_W + BYTE_W - 1) / BYTE_W;
  localparam int unsigned CNT_W  = $clog2(NB + 1);
  // Unused high bits of the last data byte.
  localparam int unsigned PAD_W  = NB * BYTE_W - KEY_W;

  // Mux-select slice p1..p4 sits at the top of the key, p1 at the LSB.
  localparam int unsigned MUX_W   = 4;
  localparam int unsigned MUX_LSB = KEY_W - MUX_W;
  localparam int unsigned MUX_MSB = KEY_W - 1;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_PAD  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [1:0] {IDLE, RECV, ERR} state_e;

endpackage

// File: rtl/key_frame_asm.sv
// Frame assembly datapath: byte-slot buffer, running XOR and padding check.
module key_frame_asm
  import key_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr,
  input  logic                   start,
  input  logic [CNT_W-1:0]       slot,
  input  logic [BYTE_W-1:0]      data,
  output logic [NB*BYTE_W-1:0]   frame,
  output logic [BYTE_W-1:0]      run_xor,
  output logic                   pad_ok
);

  logic [NB-1:0][BYTE_W-1:0] frame_q;
  logic [BYTE_W-1:0]         xor_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      xor_q   <= '0;
    end else if (flush) begin
      frame_q <= '0;
      xor_q   <= '0;
    end else if (wr) begin
      frame_q[slot] <= data;
      xor_q         <= start ? data : (xor_q ^ data);
    end
  end

  assign frame   = frame_q;
  assign run_xor = xor_q;

  if (PAD_W > 0) begin : g_pad
    assign pad_ok = (frame_q[NB-1][BYTE_W-1 -: PAD_W] == '0);
  end else begin : g_no_pad
    assign pad_ok = 1'b1;
  end

endmodule

// File: rtl/key_load_ctrl.sv
// Byte-serial key loader: frame FSM, inter-byte timeout and atomic key commit.
module key_load_ctrl
  import key_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  input  logic              clear,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_valid,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam int unsigned     IDLE_W     = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(NB);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic                key_valid_q, key_valid_d;
  logic                done_q, done_d;
  logic [1:0]          code_q, code_d;

  logic                accept;
  logic                asm_wr;
  logic                asm_start;
  logic [CNT_W-1:0]    asm_slot;
  logic [NB*BYTE_W-1:0] frame;
  logic [BYTE_W-1:0]   run_xor;
  logic                pad_ok;

  assign in_ready  = (state_q != ERR);
  assign accept    = in_valid && in_ready;
  assign asm_start = (state_q == IDLE);
  assign asm_slot  = asm_start ? '0 : cnt_q;
  // The checksum byte (slot NB) is compared, never stored.
  assign asm_wr    = accept && !clear &&
                     ((state_q == IDLE) || ((state_q == RECV) && (cnt_q != LAST_CNT)));

  key_frame_asm u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (clear),
    .wr      (asm_wr),
    .start   (asm_start),
    .slot    (asm_slot),
    .data    (in_data),
    .frame   (frame),
    .run_xor (run_xor),
    .pad_ok  (pad_ok)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    code_d      = code_q;
    done_d      = 1'b0;

    if (clear) begin
      state_d     = IDLE;
      cnt_d       = '0;
      idle_d      = '0;
      key_d       = '0;
      key_valid_d = 1'b0;
      code_d      = ERR_NONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = RECV;
            cnt_d   = CNT_W'(1);
            idle_d  = '0;
          end
        end
        RECV: begin
          if (accept) begin
            idle_d = '0;
            if (cnt_q == LAST_CNT) begin
              cnt_d = '0;
              if (run_xor != in_data) begin
                state_d = ERR;
                code_d  = ERR_CSUM;
              end else if (!pad_ok) begin
                state_d = ERR;
                code_d  = ERR_PAD;
              end else begin
                state_d     = IDLE;
                key_d       = frame[KEY_W-1:0];
                key_valid_d = 1'b1;
                done_d      = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (idle_q == IDLE_LIMIT) begin
            state_d = ERR;
            code_d  = ERR_TMO;
            cnt_d   = '0;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        ERR: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idle_q      <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      done_q      <= 1'b0;
      code_q      <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      done_q      <= done_d;
      code_q      <= code_d;
    end
  end

  assign key_out   = key_q;
  assign key_valid = key_valid_q;
  assign done      = done_q;
  assign err       = (state_q == ERR);
  assign err_code  = code_q;
  assign busy      = (state_q == RECV);

endmodule

// File: tb/tb_key_load_ctrl.sv
// Scoreboard bench for key_load_ctrl: stimulus queues expected commits/errors, monitor checks them.
module tb_key_load_ctrl;
  import key_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              clear;
  logic [KEY_W-1:0]  key_out;
  logic              key_valid;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic              busy;

  key_load_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .clear     (clear),
    .key_out   (key_out),
    .key_valid (key_valid),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       code;
    logic [KEY_W-1:0] key;
    logic             valid;
  } err_exp_t;

  logic [KEY_W-1:0] commit_q[$];
  err_exp_t         err_q[$];

  int total = 0;
  int bad   = 0;
  int done_seen = 0;

  localparam logic [KEY_W-1:0] KEY_A = 45'h1F8967452301;
  localparam logic [KEY_W-1:0] KEY_B = 45'h0A9876543210;

  logic [7:0] fr_a   [7] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'h1F, 8'h96};
  logic [7:0] fr_csum[7] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'h1F, 8'h97};
  logic [7:0] fr_pad [7] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'h3F, 8'hB6};
  logic [7:0] fr_b   [7] = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'h0A, 8'h92};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] f[7], input int max_gap);
    for (int i = 0; i < 7; i++) begin
      send(f[i], (i == 0 || max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Monitor: every done pulse or err rising edge must match the head of its queue.
  logic             err_prev = 1'b0;
  logic [KEY_W-1:0] mon_key;
  err_exp_t         mon_err;

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_seen++;
      if (commit_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected: got done=1 key=%0h want no commit", key_out);
      end else begin
        mon_key = commit_q.pop_front();
        check("commit_key", 64'(key_out), 64'(mon_key));
        check("commit_valid", 64'(key_valid), 64'd1);
      end
    end
    if (rst_n && err && !err_prev) begin
      if (err_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL err_unexpected: got err=1 code=%0b want no error", err_code);
      end else begin
        mon_err = err_q.pop_front();
        check("err_code", 64'(err_code), 64'(mon_err.code));
        check("err_key_hold", 64'(key_out), 64'(mon_err.key));
        check("err_valid_hold", 64'(key_valid), 64'(mon_err.valid));
      end
    end
    err_prev = err;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    clear    = 1'b0;
    #12;
    check("rst_key_out", 64'(key_out), 64'd0);
    check("rst_key_valid", 64'(key_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Good frame
    commit_q.push_back(KEY_A);
    send(fr_a[0], 0);
    check("busy_after_first", 64'(busy), 64'd1);
    for (int i = 1; i < 7; i++) send(fr_a[i], 0);
    check("good_done", 64'(done), 64'd1);
    check("good_key", 64'(key_out), 64'h1F8967452301);
    check("good_mux", 64'(key_out[MUX_MSB:MUX_LSB]), 64'hF);
    check("good_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);

    // Bad checksum keeps prior key
    err_q.push_back('{code: 2'b01, key: KEY_A, valid: 1'b1});
    send_frame(fr_csum, 0);
    check("csum_err", 64'(err), 64'd1);
    check("csum_in_ready", 64'(in_ready), 64'd0);
    check("csum_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    check("csum_key_hold", 64'(key_out), 64'h1F8967452301);
    pulse_clear();
    check("clr_key_out", 64'(key_out), 64'd0);
    check("clr_err", 64'(err), 64'd0);
    check("clr_err_code", 64'(err_code), 64'd0);
    check("clr_in_ready", 64'(in_ready), 64'd1);

    // Bad padding after a fresh good key
    commit_q.push_back(KEY_A);
    send_frame(fr_a, 0);
    err_q.push_back('{code: 2'b10, key: KEY_A, valid: 1'b1});
    send_frame(fr_pad, 0);
    check("pad_err_code", 64'(err_code), 64'b10);
    check("pad_valid_hold", 64'(key_valid), 64'd1);
    pulse_clear();

    // Timeout: 3 bytes then idle
    for (int i = 0; i < 3; i++) send(fr_a[i], 0);
    repeat (15) @(negedge clk);
    check("tmo_not_yet", 64'(err), 64'd0);
    check("tmo_busy", 64'(busy), 64'd1);
    err_q.push_back('{code: 2'b11, key: '0, valid: 1'b0});
    @(negedge clk);
    check("tmo_err", 64'(err), 64'd1);
    check("tmo_code", 64'(err_code), 64'b11);
    pulse_clear();
    check("tmo_clr_key", 64'(key_out), 64'd0);
    check("tmo_clr_valid", 64'(key_valid), 64'd0);
    check("tmo_clr_ready", 64'(in_ready), 64'd1);

    // Back-to-back frames with random intra-frame gaps
    begin
      int d0;
      d0 = done_seen;
      commit_q.push_back(KEY_A);
      commit_q.push_back(KEY_B);
      send_frame(fr_a, 3);
      send_frame(fr_b, 3);
      @(negedge clk);
      check("b2b_done_count", 64'(done_seen - d0), 64'd2);
      check("b2b_key", 64'(key_out), 64'h0A9876543210);
      check("b2b_mux", 64'(key_out[MUX_MSB:MUX_LSB]), 64'h5);
    end

    // Asynchronous reset mid-frame
    for (int i = 0; i < 4; i++) send(fr_a[i], 0);
    check("mid_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_key_out", 64'(key_out), 64'd0);
    check("arst_key_valid", 64'(key_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // clear coincident with the checksum byte discards the frame
    for (int i = 0; i < 6; i++) send(fr_a[i], 0);
    clear = 1'b1;
    send(fr_a[6], 0);
    clear = 1'b0;
    check("clr_cs_valid", 64'(key_valid), 64'd0);
    check("clr_cs_key", 64'(key_out), 64'd0);
    check("clr_cs_busy", 64'(busy), 64'd0);
    @(negedge clk);

    commit_q.push_back(KEY_B);
    send_frame(fr_b, 0);
    repeat (3) @(negedge clk);
    check("commit_queue_empty", 64'(commit_q.size()), 64'd0);
    check("err_queue_empty", 64'(err_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
